pend_scan32: RTL and testbench

Pending-event scanner that sits directly upstream of `pe32_5` and turns its combinational pick into a sequential stream. It accumulates 32 event bits into a pending register and uses `pe32_5` to select the highest-index pending bit. Each selected index is issued on a registered valid/ready output, and its bit is retired. Events that arrive while their bit is already pending are coalesced and counted.

---
 rtl/pend_scan_pkg.sv | 7 +
 rtl/pe32_5.sv | 15 +
 rtl/pend_scan32.sv | 95 +++++++++
 tb/tb_pend_scan32.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pend_scan_pkg.sv
// Shared types and widths for the pending-event scanner.
package pend_scan_pkg;
  localparam int VEC_W = 32;
  localparam int IDX_W = 5;

  typedef enum logic {EMPTY = 1'b0, OFFER = 1'b1} state_t;
endpackage

// File: rtl/pe32_5.sv
// 32-to-5 priority encoder: index of the highest set bit, plus an any-set flag.
module pe32_5 (
  input  logic [31:0] i_req,
  output logic [4:0]  o_idx,
  output logic        o_v
);
  always_comb begin
    o_idx = '0;
    // Ascending scan so the highest set bit wins.
    for (int i = 0; i < 32; i++)
      if (i_req[i]) o_idx = 5'(i);
  end

  assign o_v = |i_req;
endmodule

// File: rtl/pend_scan32.sv
// Pending-event scanner: accumulates event bits and issues the highest pending
// index on a registered valid/ready port, counting coalesced re-sets.
module pend_scan32
  import pend_scan_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VEC_W-1:0] set_vec,
  input  logic             set_en,
  input  logic             flush,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] pending,
  output logic [CNT_W-1:0] coal_cnt
);
  localparam int SW = CNT_W + 6;

  function automatic logic [5:0] popcnt(input logic [VEC_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < VEC_W; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [VEC_W-1:0] r_pend;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;

  logic [IDX_W-1:0] w_pick;
  logic             w_v;
  logic             w_load;
  logic [VEC_W-1:0] w_clr, w_set, w_pend_nxt;
  logic [5:0]       w_coal;
  logic [SW-1:0]    w_sum, w_max;
  logic [CNT_W-1:0] w_cnt_nxt;

  pe32_5 u_pe (
    .i_req (r_pend),
    .o_idx (w_pick),
    .o_v   (w_v)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      EMPTY: if (w_v) begin
        w_load      = 1'b1;
        w_state_nxt = OFFER;
      end
      OFFER: if (out_ready) begin
        if (w_v) w_load = 1'b1;
        else     w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // A bit being retired and re-set on the same edge is a new event, not a coalesce.
  assign w_clr      = w_load ? (VEC_W'(1) << w_pick) : '0;
  assign w_set      = set_en ? set_vec : '0;
  assign w_pend_nxt = (r_pend & ~w_clr) | w_set;
  assign w_coal     = popcnt(w_set & r_pend & ~w_clr);
  assign w_sum      = SW'(r_cnt) + SW'(w_coal);
  assign w_max      = SW'({CNT_W{1'b1}});
  assign w_cnt_nxt  = (w_sum > w_max) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_pend  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_pend  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) r_idx <= w_pick;
    end
  end

  assign out_idx   = r_idx;
  assign out_valid = (r_state == OFFER);
  assign pending   = r_pend;
  assign coal_cnt  = r_cnt;
endmodule

// File: tb/tb_pend_scan32.sv
// Scoreboard bench for pend_scan32: expected indices queued at stimulus time,
// popped on each observed transfer.
module tb_pend_scan32;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] set_vec;
  logic        set_en, flush, out_ready;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic [31:0] pending;
  logic [7:0]  coal_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  pend_scan32 #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .set_vec   (set_vec),
    .set_en    (set_en),
    .flush     (flush),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .coal_cnt  (coal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Transfer monitor: sampled on the falling edge, ahead of the edge that commits it.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_xfer", {27'b0, out_idx}, 32'hFFFF_FFFF);
      else                   chk("idx", {27'b0, out_idx}, 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_set(input logic [31:0] v);
    set_vec = v; set_en = 1'b1;
    step();
    set_en = 1'b0; set_vec = '0;
  endtask

  task automatic wait_valid(input string tag, input int lim);
    int n = 0;
    while (!out_valid && n < lim) begin step(); n++; end
    if (!out_valid) chk(tag, 32'(n), 32'(lim + 1));
  endtask

  task automatic wait_drain(input string tag, input int lim);
    int n = 0;
    while ((out_valid || exp_q.size() != 0) && n < lim) begin step(); n++; end
    chk(tag, {31'b0, out_valid}, 32'd0);
    chk({tag, "_q"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1; step(); flush = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    reset = 1'b1; set_vec = '0; set_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_idx", {27'b0, out_idx}, 32'd0);
    chk("rst_pend", pending, 32'd0);
    chk("rst_cnt", {24'b0, coal_cnt}, 32'd0);
    @(negedge clk); reset = 1'b0;
    step();

    // Single event: offer two edges after the set edge.
    out_ready = 1'b1;
    exp_q.push_back(28);
    pulse_set(32'h1000_0000);
    chk("lat_c1_valid", {31'b0, out_valid}, 32'd0);
    chk("lat_c1_pend", pending, 32'h1000_0000);
    step();
    chk("lat_c2_valid", {31'b0, out_valid}, 32'd1);
    chk("lat_c2_idx", {27'b0, out_idx}, 32'd28);
    step();
    chk("single_drop", {31'b0, out_valid}, 32'd0);
    chk("single_pend", pending, 32'd0);

    // Back-to-back drain with no bubbles.
    for (int i = 15; i >= 0; i--) exp_q.push_back(i);
    pulse_set(32'h0000_FFFF);
    wait_valid("b2b_timeout", 10);
    for (int i = 0; i < 16; i++) begin
      chk("b2b_nogap", {31'b0, out_valid}, 32'd1);
      step();
    end
    chk("b2b_end", {31'b0, out_valid}, 32'd0);

    // Backpressure: index held stable, remainder pending.
    out_ready = 1'b0;
    pulse_set(32'h0000_00FF);
    wait_valid("bp_timeout", 10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_idx", {27'b0, out_idx}, 32'd7);
      chk("bp_pend", pending, 32'h0000_007F);
      step();
    end
    for (int i = 7; i >= 0; i--) exp_q.push_back(i);
    out_ready = 1'b1;
    wait_drain("bp_drain", 20);

    // Coalesce up to saturation while idx 23 stays in flight.
    out_ready = 1'b0;
    pulse_set(32'h00FF_FF00);
    wait_valid("coal_timeout", 10);
    chk("coal_inflight", {27'b0, out_idx}, 32'd23);
    exp_cnt = 0;
    for (int k = 0; k < 34; k++) begin
      pulse_set(32'h00FF_0000);
      exp_cnt = exp_cnt + ((k == 0) ? 7 : 8);
      if (exp_cnt > 255) exp_cnt = 255;
      chk("coal_cnt", {24'b0, coal_cnt}, 32'(exp_cnt));
    end
    chk("coal_sat", {24'b0, coal_cnt}, 32'd255);
    chk("coal_pend", pending, 32'h00FF_FF00);
    exp_q.push_back(23);
    for (int i = 23; i >= 8; i--) exp_q.push_back(i);
    out_ready = 1'b1;
    wait_drain("coal_drain", 40);
    chk("coal_keep", {24'b0, coal_cnt}, 32'd255);
    do_flush();
    chk("flush_cnt", {24'b0, coal_cnt}, 32'd0);

    // Re-set of bit 5 on its load edge: issued twice, not counted.
    exp_q.push_back(5); exp_q.push_back(5);
    set_vec = 32'h20; set_en = 1'b1;
    step(); step();
    set_en = 1'b0; set_vec = '0;
    wait_drain("reset5_drain", 10);
    chk("reset5_cnt", {24'b0, coal_cnt}, 32'd0);

    // Flush beats a simultaneous set.
    out_ready = 1'b0;
    pulse_set(32'h0000_00FF);
    pulse_set(32'h0000_0003);
    wait_valid("fl_timeout", 10);
    flush = 1'b1; set_en = 1'b1; set_vec = 32'hFFFF_FFFF;
    step();
    flush = 1'b0; set_en = 1'b0; set_vec = '0;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_idx", {27'b0, out_idx}, 32'd0);
    chk("fl_pend", pending, 32'd0);
    chk("fl_cnt", {24'b0, coal_cnt}, 32'd0);
    step();
    chk("fl_stay", {31'b0, out_valid}, 32'd0);

    // Async reset in the middle of a drain.
    out_ready = 1'b1;
    for (int i = 15; i >= 0; i--) exp_q.push_back(i);
    pulse_set(32'h0000_FFFF);
    wait_valid("ar_timeout", 10);
    step(); step();
    #1 reset = 1'b1;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_idx", {27'b0, out_idx}, 32'd0);
    chk("ar_pend", pending, 32'd0);
    exp_q.delete();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_stay", {31'b0, out_valid}, 32'd0);
      chk("ar_stay_pend", pending, 32'd0);
    end
    exp_q.push_back(2);
    pulse_set(32'h4);
    wait_valid("ar_restart", 10);
    wait_drain("ar_drain", 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
